// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with a one-instruction branch delay slot.
//
// Each unstalled cycle pc advances by INCR, or, one cycle after an accepted
// redirect (the delay slot), loads the latched redirect target. When pc is
// loaded with HALT_ADDR, fetch stops and halt stays set until reset.
//
// Optional feature, enabled by defining PC_SEQUENCER_EXCEPTION_EN: the
// exception entry (exc_valid, EXC_VECTOR, epc, exc_bd).
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   stall            holds all state while high
//   redirect_valid   branch/jump taken by the instruction at pc
//   redirect_target  destination of the redirect
//   exc_valid        (optional) exception request, has priority over redirect
//   pc               current fetch address (registered)
//   pc_next_seq      pc + INCR, combinational (link address source)
//   epc              (optional) exception return address
//   exc_bd           (optional) exception was taken in a delay slot
//   in_delay_slot    current pc is a delay-slot fetch
//   halt             sticky, set once pc has loaded HALT_ADDR
//   redirect_err     one-cycle pulse for a redirect issued from a delay slot

module pc_sequencer #(
    parameter int unsigned       ADDR_W       = 32,
`ifdef PC_SEQUENCER_EXCEPTION_EN
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'hBFC00380,
`endif
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [ADDR_W-1:0] HALT_ADDR    = 32'h00000000,
    parameter int unsigned       INCR         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
`ifdef PC_SEQUENCER_EXCEPTION_EN
    input  logic              exc_valid,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_bd,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next_seq,
    output logic              in_delay_slot,
    output logic              halt,
    output logic              redirect_err
);

    localparam logic [ADDR_W-1:0] IncrW = ADDR_W'(INCR);

    typedef enum logic [1:0] {StRun, StDelay, StHalted} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              in_ds_q, in_ds_d;
    logic              halt_q, halt_d;
    logic              rerr_q, rerr_d;
`ifdef PC_SEQUENCER_EXCEPTION_EN
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              exc_bd_q, exc_bd_d;
`endif

    // Wraps silently at the top of the address space.
    assign pc_next_seq = pc_q + IncrW;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        in_ds_d  = in_ds_q;
        halt_d   = halt_q;
        rerr_d   = 1'b0;
`ifdef PC_SEQUENCER_EXCEPTION_EN
        epc_d    = epc_q;
        exc_bd_d = exc_bd_q;
`endif
        if (!stall && state_q != StHalted) begin
`ifdef PC_SEQUENCER_EXCEPTION_EN
            if (exc_valid) begin
                pc_d     = EXC_VECTOR;
                state_d  = StRun;
                target_d = '0;
                in_ds_d  = 1'b0;
                if (state_q == StDelay) begin
                    // The branch owning this slot sits one instruction back.
                    epc_d    = pc_q - IncrW;
                    exc_bd_d = 1'b1;
                end else begin
                    epc_d    = pc_q;
                    exc_bd_d = 1'b0;
                end
            end else
`endif
            if (state_q == StDelay) begin
                // A redirect from a delay slot is illegal: drop it, flag it.
                pc_d    = target_q;
                in_ds_d = 1'b0;
                state_d = StRun;
                rerr_d  = redirect_valid;
            end else if (redirect_valid) begin
                pc_d     = pc_next_seq;
                target_d = redirect_target;
                in_ds_d  = 1'b1;
                state_d  = StDelay;
            end else begin
                pc_d    = pc_next_seq;
                in_ds_d = 1'b0;
            end

            // Any load of the halt address stops fetch on the same edge.
            if (pc_d == HALT_ADDR) begin
                halt_d  = 1'b1;
                state_d = StHalted;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            pc_q     <= RESET_VECTOR;
            target_q <= '0;
            in_ds_q  <= 1'b0;
            halt_q   <= 1'b0;
            rerr_q   <= 1'b0;
`ifdef PC_SEQUENCER_EXCEPTION_EN
            epc_q    <= '0;
            exc_bd_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            in_ds_q  <= in_ds_d;
            halt_q   <= halt_d;
            rerr_q   <= rerr_d;
`ifdef PC_SEQUENCER_EXCEPTION_EN
            epc_q    <= epc_d;
            exc_bd_q <= exc_bd_d;
`endif
        end
    end

    assign pc            = pc_q;
    assign in_delay_slot = in_ds_q;
    assign halt          = halt_q;
    assign redirect_err  = rerr_q;
`ifdef PC_SEQUENCER_EXCEPTION_EN
    assign epc           = epc_q;
    assign exc_bd        = exc_bd_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        in_delay_slot;
    logic        halt;
    logic        redirect_err;
`ifdef PC_SEQUENCER_EXCEPTION_EN
    logic        exc_valid = 1'b0;
    logic [31:0] epc;
    logic        exc_bd;
`endif

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
`ifdef PC_SEQUENCER_EXCEPTION_EN
        .exc_valid       (exc_valid),
        .epc             (epc),
        .exc_bd          (exc_bd),
`endif
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .in_delay_slot   (in_delay_slot),
        .halt            (halt),
        .redirect_err    (redirect_err)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then run to pc=BFC00008.
    task automatic reset_to_08();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (pc !== 32'hBFC00000) begin
            bad++; $display("FAIL reset_pc got=%h want=bfc00000", pc);
        end
        total++;
        if ({halt, in_delay_slot, redirect_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {halt, in_delay_slot, redirect_err});
        end
        total++;
        if (pc_next_seq !== 32'hBFC00004) begin
            bad++; $display("FAIL reset_next_seq got=%h want=bfc00004", pc_next_seq);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp [3] = '{32'hBFC00004, 32'hBFC00008, 32'hBFC0000C};
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc !== exp[i] || halt !== 1'b0) begin
                bad++; $display("FAIL seq_%0d got=%h/%b want=%h/0", i, pc, halt, exp[i]);
            end
        end
    endtask

    task automatic test_redirect();
        reset_to_08();
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (pc !== 32'hBFC0000C || in_delay_slot !== 1'b1) begin
            bad++; $display("FAIL redir_slot got=%h/%b want=bfc0000c/1", pc, in_delay_slot);
        end
        tick();
        total++;
        if (pc !== 32'hBFC00100 || in_delay_slot !== 1'b0 || redirect_err !== 1'b0) begin
            bad++; $display("FAIL redir_target got=%h/%b/%b want=bfc00100/0/0",
                            pc, in_delay_slot, redirect_err);
        end
        tick();
        total++;
        if (pc !== 32'hBFC00104) begin
            bad++; $display("FAIL redir_after got=%h want=bfc00104", pc);
        end
    endtask

    task automatic test_stall_in_delay();
        reset_to_08();
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        tick();
        // Stall with a stray redirect asserted: must be ignored, no error.
        stall = 1'b1; redirect_target = 32'hBFC00200;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc !== 32'hBFC0000C || in_delay_slot !== 1'b1 || redirect_err !== 1'b0) begin
                bad++; $display("FAIL stall_hold_%0d got=%h/%b/%b want=bfc0000c/1/0",
                                i, pc, in_delay_slot, redirect_err);
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
        tick();
        total++;
        if (pc !== 32'hBFC00100) begin
            bad++; $display("FAIL stall_release got=%h want=bfc00100", pc);
        end
    endtask

    task automatic test_back_to_back();
        reset_to_08();
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        tick();
        redirect_target = 32'hBFC00200;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (pc !== 32'hBFC00100 || redirect_err !== 1'b1) begin
            bad++; $display("FAIL b2b_err got=%h/%b want=bfc00100/1", pc, redirect_err);
        end
        tick();
        total++;
        if (pc !== 32'hBFC00104 || redirect_err !== 1'b0 || in_delay_slot !== 1'b0) begin
            bad++; $display("FAIL b2b_pulse got=%h/%b/%b want=bfc00104/0/0",
                            pc, redirect_err, in_delay_slot);
        end
    endtask

    task automatic test_halt();
        reset_to_08();
        redirect_valid = 1'b1; redirect_target = 32'h00000000;
        tick();
        redirect_valid = 1'b0;
        total++;
        if (halt !== 1'b0) begin
            bad++; $display("FAIL halt_early got=%b want=0", halt);
        end
        tick();
        total++;
        if (pc !== 32'h0 || halt !== 1'b1) begin
            bad++; $display("FAIL halt_set got=%h/%b want=00000000/1", pc, halt);
        end
        redirect_valid = 1'b1; redirect_target = 32'hBFC00200;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++;
        if (pc !== 32'h0 || halt !== 1'b1 || redirect_err !== 1'b0) begin
            bad++; $display("FAIL halt_hold got=%h/%b/%b want=00000000/1/0", pc, halt, redirect_err);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (pc !== 32'hBFC00000 || halt !== 1'b0) begin
            bad++; $display("FAIL halt_reset got=%h/%b want=bfc00000/0", pc, halt);
        end
        tick();
        total++;
        if (pc !== 32'hBFC00004) begin
            bad++; $display("FAIL halt_restart got=%h want=bfc00004", pc);
        end
    endtask

    // Top of address space: sequential wrap lands on HALT_ADDR (0).
    task automatic test_wrap();
        reset_to_08();
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++;
        if (pc !== 32'hFFFFFFFC || pc_next_seq !== 32'h0 || halt !== 1'b0) begin
            bad++; $display("FAIL wrap_top got=%h/%h/%b want=fffffffc/00000000/0",
                            pc, pc_next_seq, halt);
        end
        tick();
        total++;
        if (pc !== 32'h0 || halt !== 1'b1) begin
            bad++; $display("FAIL wrap_halt got=%h/%b want=00000000/1", pc, halt);
        end
    endtask

    task automatic test_reset_in_delay();
        reset_to_08();
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        tick();
        redirect_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (pc !== 32'hBFC00000 || in_delay_slot !== 1'b0) begin
            bad++; $display("FAIL rst_delay got=%h/%b want=bfc00000/0", pc, in_delay_slot);
        end
        tick();
        total++;
        if (pc !== 32'hBFC00004) begin
            bad++; $display("FAIL rst_delay_drop got=%h want=bfc00004", pc);
        end
    endtask

`ifdef PC_SEQUENCER_EXCEPTION_EN
    task automatic test_exception();
        reset_to_08();
        total++;
        if (epc !== 32'h0 || exc_bd !== 1'b0) begin
            bad++; $display("FAIL exc_reset got=%h/%b want=00000000/0", epc, exc_bd);
        end
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        tick();
        redirect_valid = 1'b0; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        total++;
        if (pc !== 32'hBFC00380 || epc !== 32'hBFC00008 || exc_bd !== 1'b1) begin
            bad++; $display("FAIL exc_delay got=%h/%h/%b want=bfc00380/bfc00008/1", pc, epc, exc_bd);
        end
        tick();
        total++;
        if (pc !== 32'hBFC00384) begin
            bad++; $display("FAIL exc_no_target got=%h want=bfc00384", pc);
        end
        exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        total++;
        if (pc !== 32'hBFC00380 || epc !== 32'hBFC00384 || exc_bd !== 1'b0) begin
            bad++; $display("FAIL exc_run got=%h/%h/%b want=bfc00380/bfc00384/0", pc, epc, exc_bd);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_in_delay();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_reset_in_delay();
`ifdef PC_SEQUENCER_EXCEPTION_EN
        test_exception();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the core's fetch program counter.
- Generates the fetch address each cycle and handles sequential increment, stall, and redirect with a one-instruction MIPS branch delay slot.
- Detects the halt address and holds; reports illegal redirects issued from inside a delay slot.
- Sits between the decode/branch-resolve stage (redirect source) and the instruction memory address port.

Parameters:
- ADDR_W, 32, width of all address ports and internal registers.
- RESET_VECTOR, 32'hBFC00000, value loaded into pc on reset.
- HALT_ADDR, 32'h00000000, address that, when loaded into pc, stops fetch.
- INCR, 4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  active-high; holds all state when 1.
- redirect_valid  input  1  branch/jump taken, issued by the instruction at current pc.
- redirect_target  input  ADDR_W  destination address of the redirect.
- pc  output  ADDR_W  current fetch address.
- pc_next_seq  output  ADDR_W  combinational pc + INCR (link-address source).
- in_delay_slot  output  1  current pc is a delay-slot fetch.
- halt  output  1  sticky; set once pc has loaded HALT_ADDR.
- redirect_err  output  1  one-cycle pulse on a redirect accepted inside a delay slot.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high, sampled on rising clk, and takes priority over every other input.
- Reset values: pc=RESET_VECTOR, state=RUN, in_delay_slot=0, halt=0, redirect_err=0, pending target=0.
- Arithmetic: pc_next_seq = pc + INCR, truncated to ADDR_W; wrap from all-ones to low addresses is silent.
- Gating: with stall=1, pc, state, the target register and halt hold, redirect_valid is ignored, and redirect_err=0.
- States (all transitions require stall=0):
  - RUN, redirect_valid=0: pc <= pc+INCR; stay in RUN.
  - RUN, redirect_valid=1: pc <= pc+INCR (delay slot); latch redirect_target; -> DELAY; in_delay_slot <= 1.
  - DELAY: pc <= latched target; in_delay_slot <= 0; -> RUN.
  - DELAY, redirect_valid=1: the new redirect is discarded, the latched target is used, and redirect_err pulses for 1 cycle.
  - HALTED: pc, in_delay_slot and halt hold; all inputs except reset are ignored.
- Halt detection: on any edge where the value written into pc equals HALT_ADDR (sequential, delay-slot or redirect load), pc takes that value, halt <= 1 on the same edge, and the next state is HALTED.
- Redirect latency: the target appears on pc exactly 2 unstalled cycles after the redirect is accepted. A stall between them extends the latency but never drops the target.
- Redirect to the current pc+INCR: no special case; the delay slot and target fetch share the same address.
- Reset during DELAY or HALTED: returns to RUN with the pending target cleared.
- Outputs pc, in_delay_slot, halt and redirect_err are registered; pc_next_seq is the only combinational output.

Optional Feature:
- Macro: PC_SEQUENCER_EXCEPTION_EN.
- When defined, adds:
  - parameter EXC_VECTOR (default 32'hBFC00380);
  - input exc_valid (1);
  - outputs epc (ADDR_W) and exc_bd (1).
- exc_valid=1 with stall=0 in RUN or DELAY, higher priority than redirect:
  - pc <= EXC_VECTOR; state -> RUN; pending target cleared.
  - If the current state is DELAY: epc <= pc-INCR and exc_bd <= 1.
  - Otherwise: epc <= pc and exc_bd <= 0.
  - exc_valid is ignored in HALTED.
- Reset values: epc=0, exc_bd=0.
- When undefined: none of these ports or the parameter exist, and behaviour is as above.

Test Plan:
- Release reset, no stall, 3 cycles -> pc sequence BFC00000, BFC00004, BFC00008, BFC0000C; halt=0.
- redirect_valid=1, target=BFC00100 at pc=BFC00008:
  - next pc=BFC0000C with in_delay_slot=1;
  - then pc=BFC00100 with in_delay_slot=0.
- Same redirect with stall=1 for 3 cycles while in DELAY -> pc holds BFC0000C throughout, then BFC00100 on the first unstalled edge.
- redirect to 00000000 -> pc=00000000 and halt=1 on the same edge; a further redirect or stall toggling leaves pc=0 and halt=1; reset returns pc=BFC00000, halt=0.
- Second redirect (target=BFC00200) while in DELAY -> redirect_err pulses 1 cycle; pc goes to the first target BFC00100.
- With PC_SEQUENCER_EXCEPTION_EN: exc_valid during DELAY at pc=BFC0000C -> pc=BFC00380, epc=BFC00008, exc_bd=1; the pending target is never fetched.
